fetch_controller: RTL and testbench
===================================

FETCH_CONTROLLER -- requirements
Module: fetch_controller

Interface
REQ-001 Parameter WAIT_MAX, default 16: maximum cycles S_REQ waits for imem_ready before a fetch error.
REQ-002 Parameter AW, default 32: address/data width, matching program_counter.
REQ-003 clk  in  1  clock; all state changes on its rising edge.
REQ-004 rst  in  1  reset, synchronous, active-low.
REQ-005 pc_i  in  32  current PC_o from program_counter.
REQ-006 pc_sel  out  2  program_counter select (RESET/HOLD/INC/JUMP).
REQ-007 pc_jumpdir  out  32  jump target to program_counter.
REQ-008 imem_req  out  1  instruction-memory request.
REQ-009 imem_addr  out  32  fetch address.
REQ-010 imem_ready  in  1  memory data valid this cycle.
REQ-011 imem_rdata  in  32  fetched instruction.
REQ-012 instr_o  out  32  instruction to decode.
REQ-013 instr_valid  out  1  instr_o valid.
REQ-014 instr_ready  in  1  decode accepts instr_o.
REQ-015 redirect  in  1  branch/jump taken request.
REQ-016 redirect_addr  in  32  redirect target.
REQ-017 halt  in  1  stop fetching.
REQ-018 halted  out  1  controller in S_HALT.
REQ-019 fetch_err  out  1  sticky memory-timeout flag.

Function
REQ-020 The FSM SHALL have states S_RESET, S_REQ, S_OUT, S_HALT. pc_sel SHALL be HOLD unless a state rule below says otherwise.
REQ-021 S_RESET: pc_sel=RESET for one cycle, then S_REQ.
REQ-022 S_REQ: imem_req=1, imem_addr=pc_i. On imem_ready, latch imem_rdata into instr_o and go to S_OUT. imem_req SHALL drop in the same cycle as imem_ready.
REQ-023 S_OUT: instr_valid=1 and instr_o stable. On instr_ready, pc_sel=INC and go to S_REQ; the next fetch address is the old pc_i+4 (one-cycle PC update latency).
REQ-024 Redirect has priority over every other event in S_REQ, S_OUT and S_HALT:
- pc_sel=JUMP, pc_jumpdir=redirect_addr;
- instr_valid=0 in that cycle and any held instruction is discarded;
- any pending request is withdrawn (imem_req=0);
- next state is S_REQ.
REQ-025 pc_jumpdir SHALL equal redirect_addr whenever redirect=1, and 0 otherwise.
REQ-026 halt, without redirect, in S_REQ (before ready) or in S_OUT (with or without a handshake) SHALL go to S_HALT.
- If an S_OUT handshake occurs in that cycle, the instruction is consumed and pc_sel=INC; otherwise pc_sel=HOLD.
- In S_HALT: pc_sel=HOLD, imem_req=0, instr_valid=0, halted=1.
REQ-027 S_HALT SHALL be left only by redirect or by rst.
REQ-028 A wait counter SHALL clear on entry to S_REQ and increment on each S_REQ cycle without imem_ready. When it reaches WAIT_MAX-1 with no ready:
- fetch_err is set to 1;
- the FSM goes to S_HALT.
REQ-029 fetch_err SHALL clear only on reset.
REQ-030 Simultaneous imem_ready and redirect in S_REQ: redirect wins and the data is dropped.

Reset
REQ-031 While rst=0: state=S_RESET, pc_sel=RESET, and pc_jumpdir, imem_req, imem_addr, instr_o, instr_valid, halted, fetch_err and the wait counter are all 0.
REQ-032 rst=0 in any state, mid-fetch or mid-handshake, SHALL abort the operation and apply REQ-031 on the next edge.

Structure
REQ-033 Shared package/header pc_ctrl_pkg SHALL hold:
- the PC select encodings RESET=2'd0, HOLD=2'd1, INC=2'd2, JUMP=2'd3, shared with program_counter;
- the FSM state encodings.
REQ-034 The wait counter SHALL be a sub-module fetch_timer (clear, enable, terminal-count output).

Verification
REQ-035 Release reset, imem_ready=1 each S_REQ cycle, instr_ready=1 -> pc_sel RESET, then alternating HOLD/INC; imem_addr 0,4,8,... every two cycles.
REQ-036 instr_ready=0 for 5 cycles in S_OUT -> instr_valid and instr_o stable, pc_sel=HOLD, PC unchanged.
REQ-037 redirect=1, redirect_addr=0x100 during S_OUT -> pc_sel=JUMP, pc_jumpdir=0x100, instr_valid=0; next imem_addr=0x100.
REQ-038 imem_ready held 0 with WAIT_MAX=16 -> fetch_err=1 and halted=1 after 16 S_REQ cycles; redirect to 0x40 resumes fetch, fetch_err stays 1.
REQ-039 rst=0 asserted mid-S_REQ -> next edge all outputs 0 and pc_sel=RESET; fetch restarts at address 0.

Source files
------------

// File: rtl/pc_ctrl_pkg.sv
// Shared definitions for the fetch controller and the program counter it steers.
package pc_ctrl_pkg;

    // Program-counter select encodings, shared with program_counter.
    typedef enum logic [1:0] {
        PC_RESET = 2'd0,
        PC_HOLD  = 2'd1,
        PC_INC   = 2'd2,
        PC_JUMP  = 2'd3
    } pc_sel_e;

    // Fetch controller FSM states.
    typedef enum logic [1:0] {
        S_RESET = 2'd0,
        S_REQ   = 2'd1,
        S_OUT   = 2'd2,
        S_HALT  = 2'd3
    } fetch_state_e;

endpackage

// File: rtl/fetch_timer.sv
// Wait counter for instruction-memory requests: clears, counts enabled cycles,
// and flags when it sits at the last permitted wait cycle (WAIT_MAX-1).
module fetch_timer
    import pc_ctrl_pkg::*;
#(
    parameter int unsigned WAIT_MAX = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clr_i,
    input  logic en_i,
    output logic tc_o
);

    localparam int unsigned CW = (WAIT_MAX > 1) ? $clog2(WAIT_MAX) : 1;
    localparam logic [CW-1:0] Terminal = CW'(WAIT_MAX - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    // Next count: clear wins, otherwise count up and park at the terminal value.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i && (cnt_q != Terminal)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Count register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tc_o = (cnt_q == Terminal);

endmodule

// File: rtl/fetch_controller.sv
// Instruction fetch controller: requests instructions at the current PC, hands them
// to decode with a valid/ready handshake, and steers program_counter via pc_sel.
// Redirects take priority everywhere except the reset cycle; a memory that never
// answers within WAIT_MAX cycles sets a sticky error and parks the FSM in S_HALT.
module fetch_controller
    import pc_ctrl_pkg::*;
#(
    parameter int unsigned WAIT_MAX = 16,
    parameter int unsigned AW       = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [AW-1:0] pc_i,
    output logic [1:0]    pc_sel,
    output logic [AW-1:0] pc_jumpdir,
    output logic          imem_req,
    output logic [AW-1:0] imem_addr,
    input  logic          imem_ready,
    input  logic [AW-1:0] imem_rdata,
    output logic [AW-1:0] instr_o,
    output logic          instr_valid,
    input  logic          instr_ready,
    input  logic          redirect,
    input  logic [AW-1:0] redirect_addr,
    input  logic          halt,
    output logic          halted,
    output logic          fetch_err
);

    fetch_state_e  state_q, state_d;
    logic [AW-1:0] instr_q, instr_d;
    logic          err_q, err_d;
    logic          tmr_en, tmr_tc;
    pc_sel_e       sel;

    // The timer only runs while a request is still outstanding and staying in S_REQ;
    // any other cycle clears it, so every entry into S_REQ starts from zero.
    fetch_timer #(
        .WAIT_MAX (WAIT_MAX)
    ) u_fetch_timer (
        .clk   (clk),
        .rst   (rst),
        .clr_i (!tmr_en),
        .en_i  (tmr_en),
        .tc_o  (tmr_tc)
    );

    // Next-state and output decode; outputs are forced to reset values while rst is low.
    always_comb begin
        state_d     = state_q;
        instr_d     = instr_q;
        err_d       = err_q;
        sel         = PC_HOLD;
        imem_req    = 1'b0;
        imem_addr   = '0;
        instr_valid = 1'b0;
        halted      = 1'b0;
        tmr_en      = 1'b0;
        pc_jumpdir  = redirect ? redirect_addr : '0;

        unique case (state_q)
            S_RESET: begin
                sel     = PC_RESET;
                state_d = S_REQ;
            end
            S_REQ: begin
                imem_addr = pc_i;
                if (redirect) begin
                    // Withdraw the request and drop any data arriving this cycle.
                    sel     = PC_JUMP;
                    instr_d = '0;
                    state_d = S_REQ;
                end else if (imem_ready) begin
                    instr_d = imem_rdata;
                    state_d = S_OUT;
                end else begin
                    imem_req = 1'b1;
                    if (tmr_tc) begin
                        err_d   = 1'b1;
                        state_d = S_HALT;
                    end else if (halt) begin
                        state_d = S_HALT;
                    end else begin
                        tmr_en = 1'b1;
                    end
                end
            end
            S_OUT: begin
                if (redirect) begin
                    sel     = PC_JUMP;
                    instr_d = '0;
                    state_d = S_REQ;
                end else begin
                    instr_valid = 1'b1;
                    if (instr_ready) begin
                        sel     = PC_INC;
                        state_d = halt ? S_HALT : S_REQ;
                    end else if (halt) begin
                        state_d = S_HALT;
                    end
                end
            end
            S_HALT: begin
                halted = 1'b1;
                if (redirect) begin
                    sel     = PC_JUMP;
                    state_d = S_REQ;
                end
            end
        endcase

        if (!rst) begin
            sel         = PC_RESET;
            imem_req    = 1'b0;
            imem_addr   = '0;
            instr_valid = 1'b0;
            halted      = 1'b0;
            tmr_en      = 1'b0;
            pc_jumpdir  = '0;
        end
    end

    // State, held instruction and sticky error, all cleared by synchronous reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= S_RESET;
            instr_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            instr_q <= instr_d;
            err_q   <= err_d;
        end
    end

    assign pc_sel    = sel;
    assign instr_o   = rst ? instr_q : '0;
    assign fetch_err = rst & err_q;

endmodule

// File: tb/tb_fetch_controller.sv
// Bench for fetch_controller: directed scenarios, then randomized traffic checked by
// a scoreboard queue holding the architectural address of the next instruction.
module tb_fetch_controller;
    import pc_ctrl_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pc_q;
    logic [1:0]  pc_sel;
    logic [31:0] pc_jumpdir;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic [31:0] instr_o;
    logic        instr_valid;
    logic        instr_ready;
    logic        redirect;
    logic [31:0] redirect_addr;
    logic        halt;
    logic        halted;
    logic        fetch_err;

    logic        dir_ready;
    logic        rnd_ready;
    logic        auto_mem;
    logic        mon_en;
    int          checks = 0;
    int          errors = 0;
    int          hs_cnt = 0;
    int          wc;
    logic [31:0] exp_q[$];

    always #5 clk = ~clk;

    fetch_controller #(
        .WAIT_MAX (16),
        .AW       (32)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .pc_i          (pc_q),
        .pc_sel        (pc_sel),
        .pc_jumpdir    (pc_jumpdir),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_ready    (imem_ready),
        .imem_rdata    (imem_rdata),
        .instr_o       (instr_o),
        .instr_valid   (instr_valid),
        .instr_ready   (instr_ready),
        .redirect      (redirect),
        .redirect_addr (redirect_addr),
        .halt          (halt),
        .halted        (halted),
        .fetch_err     (fetch_err)
    );

    // Instruction memory contents: a fixed hash of the address.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
    endfunction

    assign imem_ready = auto_mem ? rnd_ready : dir_ready;
    assign imem_rdata = mem_word(imem_addr);

    // Environment model of program_counter.
    always @(posedge clk) begin
        case (pc_sel)
            2'd0:    pc_q <= 32'h0;
            2'd2:    pc_q <= pc_q + 32'd4;
            2'd3:    pc_q <= pc_jumpdir;
            default: pc_q <= pc_q;
        endcase
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic drive_next();
        @(posedge clk);
        #1;
    endtask

    task automatic samp();
        @(negedge clk);
    endtask

    // Random memory responder: answers within at most six request cycles.
    initial begin
        wc = 0;
        rnd_ready = 1'b0;
        forever begin
            @(negedge clk);
            wc = imem_req ? wc + 1 : 0;
            @(posedge clk);
            #1;
            rnd_ready = (wc >= 5) || ($urandom_range(0, 2) == 0);
        end
    end

    // Scoreboard monitor: compares every presented output against the expected stream.
    always @(negedge clk) begin : monitor
        logic [31:0] nxt;
        if (mon_en && rst && (exp_q.size() != 0)) begin
            nxt = exp_q[0];
            chk("rnd_jumpdir", pc_jumpdir, redirect ? redirect_addr : 32'h0);
            chk("rnd_fetch_err", 32'(fetch_err), 32'h0);
            if (redirect) begin
                chk("rnd_redir_sel", 32'(pc_sel), 32'(PC_JUMP));
                chk("rnd_redir_valid", 32'(instr_valid), 32'h0);
                chk("rnd_redir_req", 32'(imem_req), 32'h0);
            end
            if (imem_req) chk("rnd_addr", imem_addr, nxt);
            if (instr_valid) begin
                chk("rnd_instr", instr_o, mem_word(nxt));
                if (instr_ready) begin
                    void'(exp_q.pop_front());
                    exp_q.push_back(nxt + 32'd4);
                    hs_cnt++;
                end
            end
        end
    end

    initial begin
        rst = 1'b0; instr_ready = 1'b0; redirect = 1'b0; redirect_addr = 32'h0;
        halt = 1'b0; dir_ready = 1'b0; auto_mem = 1'b0; mon_en = 1'b0; pc_q = 32'h0;

        // Reset values.
        repeat (2) drive_next();
        samp();
        chk("rst_sel", 32'(pc_sel), 32'(PC_RESET));
        chk("rst_req", 32'(imem_req), 32'h0);
        chk("rst_addr", imem_addr, 32'h0);
        chk("rst_valid", 32'(instr_valid), 32'h0);
        chk("rst_instr", instr_o, 32'h0);
        chk("rst_halted", 32'(halted), 32'h0);
        chk("rst_err", 32'(fetch_err), 32'h0);
        chk("rst_jumpdir", pc_jumpdir, 32'h0);

        // Streaming fetch with ready memory and ready decode.
        drive_next(); rst = 1'b1; dir_ready = 1'b1; instr_ready = 1'b1; samp();
        chk("first_sel_reset", 32'(pc_sel), 32'(PC_RESET));
        for (int k = 0; k < 4; k++) begin
            drive_next(); samp();
            chk("req_sel_hold", 32'(pc_sel), 32'(PC_HOLD));
            chk("req_addr", imem_addr, 32'(4 * k));
            chk("req_drop_on_ready", 32'(imem_req), 32'h0);
            drive_next(); instr_ready = (k < 3); samp();
            chk("out_valid", 32'(instr_valid), 32'h1);
            chk("out_instr", instr_o, mem_word(32'(4 * k)));
            chk("out_sel", 32'(pc_sel), (k < 3) ? 32'(PC_INC) : 32'(PC_HOLD));
        end

        // Decode stall: output held, PC unchanged.
        repeat (4) begin
            drive_next(); samp();
            chk("stall_valid", 32'(instr_valid), 32'h1);
            chk("stall_instr", instr_o, mem_word(32'd12));
            chk("stall_sel", 32'(pc_sel), 32'(PC_HOLD));
            chk("stall_pc", pc_q, 32'd12);
        end

        // Redirect during S_OUT beats the handshake.
        drive_next(); redirect = 1'b1; redirect_addr = 32'h100; instr_ready = 1'b1; samp();
        chk("redir_sel", 32'(pc_sel), 32'(PC_JUMP));
        chk("redir_jumpdir", pc_jumpdir, 32'h100);
        chk("redir_valid", 32'(instr_valid), 32'h0);
        chk("redir_req", 32'(imem_req), 32'h0);
        drive_next(); redirect = 1'b0; redirect_addr = 32'h0; instr_ready = 1'b0;
        dir_ready = 1'b0; samp();
        chk("redir_next_addr", imem_addr, 32'h100);
        chk("redir_next_req", 32'(imem_req), 32'h1);
        chk("jumpdir_idle", pc_jumpdir, 32'h0);

        // Memory timeout: 16 S_REQ cycles without ready.
        for (int i = 2; i <= 16; i++) begin
            drive_next(); samp();
            chk("wait_req", 32'(imem_req), 32'h1);
            chk("wait_not_halted", 32'(halted), 32'h0);
        end
        drive_next(); samp();
        chk("tmo_halted", 32'(halted), 32'h1);
        chk("tmo_err", 32'(fetch_err), 32'h1);
        chk("tmo_req", 32'(imem_req), 32'h0);
        chk("tmo_sel", 32'(pc_sel), 32'(PC_HOLD));
        repeat (2) begin
            drive_next(); samp();
            chk("halt_stays", 32'(halted), 32'h1);
        end
        drive_next(); redirect = 1'b1; redirect_addr = 32'h40; samp();
        chk("halt_redir_sel", 32'(pc_sel), 32'(PC_JUMP));
        chk("halt_redir_jumpdir", pc_jumpdir, 32'h40);
        drive_next(); redirect = 1'b0; redirect_addr = 32'h0; dir_ready = 1'b1; samp();
        chk("resume_addr", imem_addr, 32'h40);
        chk("resume_halted", 32'(halted), 32'h0);
        chk("resume_err_sticky", 32'(fetch_err), 32'h1);
        drive_next(); instr_ready = 1'b1; samp();
        chk("resume_valid", 32'(instr_valid), 32'h1);
        chk("resume_instr", instr_o, mem_word(32'h40));

        // Halt while waiting in S_REQ.
        drive_next(); instr_ready = 1'b0; dir_ready = 1'b0; halt = 1'b1; samp();
        chk("hreq_addr", imem_addr, 32'h44);
        chk("hreq_req", 32'(imem_req), 32'h1);
        drive_next(); halt = 1'b0; samp();
        chk("hreq_halted", 32'(halted), 32'h1);
        chk("hreq_sel", 32'(pc_sel), 32'(PC_HOLD));
        chk("hreq_pc", pc_q, 32'h44);
        repeat (3) begin
            drive_next(); samp();
            chk("hreq_stay", 32'(halted), 32'h1);
            chk("hreq_noreq", 32'(imem_req), 32'h0);
        end

        // Halt together with a handshake in S_OUT consumes the instruction.
        drive_next(); redirect = 1'b1; redirect_addr = 32'h80; samp();
        drive_next(); redirect = 1'b0; redirect_addr = 32'h0; dir_ready = 1'b1; samp();
        chk("hout_addr", imem_addr, 32'h80);
        drive_next(); instr_ready = 1'b1; halt = 1'b1; samp();
        chk("hout_valid", 32'(instr_valid), 32'h1);
        chk("hout_sel", 32'(pc_sel), 32'(PC_INC));
        chk("hout_instr", instr_o, mem_word(32'h80));
        drive_next(); halt = 1'b0; instr_ready = 1'b0; samp();
        chk("hout_halted", 32'(halted), 32'h1);
        chk("hout_pc", pc_q, 32'h84);
        chk("hout_novalid", 32'(instr_valid), 32'h0);

        // Reset asserted mid-S_REQ.
        drive_next(); redirect = 1'b1; redirect_addr = 32'h200; samp();
        drive_next(); redirect = 1'b0; redirect_addr = 32'h0; dir_ready = 1'b0; samp();
        chk("mid_addr", imem_addr, 32'h200);
        chk("mid_req", 32'(imem_req), 32'h1);
        drive_next(); rst = 1'b0; samp();
        chk("mid_rst_sel", 32'(pc_sel), 32'(PC_RESET));
        drive_next(); samp();
        chk("mid_rst_req", 32'(imem_req), 32'h0);
        chk("mid_rst_addr", imem_addr, 32'h0);
        chk("mid_rst_instr", instr_o, 32'h0);
        chk("mid_rst_halted", 32'(halted), 32'h0);
        chk("mid_rst_err", 32'(fetch_err), 32'h0);
        chk("mid_rst_sel2", 32'(pc_sel), 32'(PC_RESET));
        drive_next(); rst = 1'b1; dir_ready = 1'b1; samp();
        chk("restart_sel", 32'(pc_sel), 32'(PC_RESET));
        drive_next(); samp();
        chk("restart_addr", imem_addr, 32'h0);
        chk("restart_pc", pc_q, 32'h0);
        chk("restart_err", 32'(fetch_err), 32'h0);

        // Randomized traffic against the scoreboard.
        drive_next(); rst = 1'b0; instr_ready = 1'b0; redirect = 1'b0; halt = 1'b0; samp();
        exp_q.delete();
        exp_q.push_back(32'h0);
        auto_mem = 1'b1;
        mon_en = 1'b1;
        drive_next(); rst = 1'b1; samp();
        for (int c = 0; c < 3000; c++) begin
            drive_next();
            instr_ready = 1'($urandom_range(0, 1));
            redirect = ($urandom_range(0, 15) == 0);
            redirect_addr = $urandom & 32'h0000_0FFC;
            if (redirect) begin
                exp_q.delete();
                exp_q.push_back(redirect_addr);
            end
        end
        samp();
        mon_en = 1'b0;
        chk("rnd_handshakes", {31'b0, hs_cnt > 100}, 32'h1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
